// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline hazard definitions: sequencer state encoding and the
// register-dependency match helper used by the hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when dst feeds rs, or rt when the consumer actually reads rt; r0 never matches.
  function automatic logic reg_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Stall/flush performance counters (two enabled, wrapping counters).
// Built only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hz_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Free-running event counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline (load-use, branch operand,
// taken-branch flush, data-memory wait). Optional counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rsaddr_i,
  input  logic [4:0]       id_rtaddr_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_branch_i,
  input  logic             id_branch_taken_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rdaddr_i,
  input  logic             mem_memread_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       mem_rdaddr_i,
  input  logic             mem_access_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             mem_wb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int              TO_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

  hz_state_t       state_r;
  hz_state_t       state_nxt_s;
  logic [TO_W-1:0] to_cnt_r;
  logic [TO_W-1:0] to_cnt_nxt_s;
  logic            err_r;
  logic            err_nxt_s;
  logic            hz_ex_s;
  logic            hz_mem_s;
  logic            freeze_s;
  logic            load_use_s;
  logic            br_hz_s;
  logic            unused_s;

  // MEM-stage write-back flag carries no hazard information for this controller.
  assign unused_s = mem_regwrite_i;

  assign hz_ex_s    = reg_match(ex_rdaddr_i, id_rsaddr_i, id_rtaddr_i, id_uses_rt_i);
  assign hz_mem_s   = reg_match(mem_rdaddr_i, id_rsaddr_i, id_rtaddr_i, id_uses_rt_i);
  assign freeze_s   = dmem_busy_i & (mem_access_i | (state_r == MEM_WAIT));
  assign load_use_s = ex_memread_i & hz_ex_s;
  assign br_hz_s    = id_is_branch_i & ((ex_regwrite_i & hz_ex_s) | (mem_memread_i & hz_mem_s));

  // Prioritised pipeline-control decode and next-state selection.
  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    id_ex_write_o   = 1'b1;
    ex_mem_write_o  = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    state_nxt_s     = RUN;
    if (!rst_n_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_bubble_o  = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (freeze_s) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
      state_nxt_s     = MEM_WAIT;
    end else if (load_use_s || br_hz_s || (state_r == BR_STALL)) begin
      // A load feeding a branch needs a second bubble, taken via BR_STALL.
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      state_nxt_s    = (load_use_s && id_is_branch_i) ? BR_STALL : RUN;
    end else if (id_branch_taken_i) begin
      if_id_flush_o = 1'b1;
    end else begin
      state_nxt_s = RUN;
    end
  end

  // Memory-wait timeout: saturating run-length of freeze cycles and sticky error.
  always_comb begin
    to_cnt_nxt_s = '0;
    err_nxt_s    = err_r;
    if (freeze_s) begin
      to_cnt_nxt_s = (to_cnt_r != TO_MAX) ? (to_cnt_r + TO_W'(1)) : to_cnt_r;
    end else begin
      to_cnt_nxt_s = '0;
    end
    if (TO_EN && freeze_s && (to_cnt_nxt_s == TO_MAX)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Sequencer state, timeout counter and error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= RUN;
      to_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      to_cnt_r <= to_cnt_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign err_o = err_r;

`ifdef HAZARD_PERF_CNT_EN
  hz_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .stall_inc (~pc_write_o),
    .flush_inc (if_id_flush_o),
    .stall_cnt (stall_cnt_o),
    .flush_cnt (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle comparison against a behavioural
// model plus hand-computed spot checks. Honours HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_W       = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rsaddr, id_rtaddr, ex_rdaddr, mem_rdaddr;
  logic             id_uses_rt, id_is_branch, id_branch_taken;
  logic             ex_memread, ex_regwrite, mem_memread, mem_regwrite;
  logic             mem_access, dmem_busy;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic             if_id_flush, id_ex_bubble, mem_wb_bubble, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // model state
  bit m_br_pend = 1'b0;
  bit m_in_wait = 1'b0;
  bit m_err     = 1'b0;
  int m_wait    = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .id_rsaddr_i      (id_rsaddr),
    .id_rtaddr_i      (id_rtaddr),
    .id_uses_rt_i     (id_uses_rt),
    .id_is_branch_i   (id_is_branch),
    .id_branch_taken_i(id_branch_taken),
    .ex_memread_i     (ex_memread),
    .ex_regwrite_i    (ex_regwrite),
    .ex_rdaddr_i      (ex_rdaddr),
    .mem_memread_i    (mem_memread),
    .mem_regwrite_i   (mem_regwrite),
    .mem_rdaddr_i     (mem_rdaddr),
    .mem_access_i     (mem_access),
    .dmem_busy_i      (dmem_busy),
    .pc_write_o       (pc_write),
    .if_id_write_o    (if_id_write),
    .id_ex_write_o    (id_ex_write),
    .ex_mem_write_o   (ex_mem_write),
    .if_id_flush_o    (if_id_flush),
    .id_ex_bubble_o   (id_ex_bubble),
    .mem_wb_bubble_o  (mem_wb_bubble),
    .err_o            (err),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rsaddr = 5'd0; id_rtaddr = 5'd0; ex_rdaddr = 5'd0; mem_rdaddr = 5'd0;
    id_uses_rt = 1'b0; id_is_branch = 1'b0; id_branch_taken = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b0; mem_regwrite = 1'b0;
    mem_access = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: derive expected controls from the hazard rules, compare, then advance.
  always @(negedge clk) begin : model_cmp
    bit hz_ex, hz_mem, frz, stl, fl;
    int mod;
    mod    = 1 << CNT_W;
    hz_ex  = (ex_rdaddr != 5'd0) && (ex_rdaddr == id_rsaddr || (id_uses_rt && ex_rdaddr == id_rtaddr));
    hz_mem = (mem_rdaddr != 5'd0) && (mem_rdaddr == id_rsaddr || (id_uses_rt && mem_rdaddr == id_rtaddr));
    frz    = dmem_busy && (mem_access || m_in_wait);
    stl    = !frz && ((ex_memread && hz_ex) || m_br_pend ||
                      (id_is_branch && ((ex_regwrite && hz_ex) || (mem_memread && hz_mem))));
    fl     = !frz && !stl && id_branch_taken;
    if (!rst_n) begin
      m_br_pend = 1'b0; m_in_wait = 1'b0; m_err = 1'b0;
      m_wait = 0; m_stall = 0; m_flush = 0;
      chk("rst_pc_write", pc_write, 0);
      chk("rst_if_id_write", if_id_write, 0);
      chk("rst_id_ex_write", id_ex_write, 0);
      chk("rst_ex_mem_write", ex_mem_write, 0);
      chk("rst_if_id_flush", if_id_flush, 1);
      chk("rst_id_ex_bubble", id_ex_bubble, 1);
      chk("rst_mem_wb_bubble", mem_wb_bubble, 1);
      chk("rst_err", err, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
    end else begin
      chk("pc_write", pc_write, !(frz || stl));
      chk("if_id_write", if_id_write, !(frz || stl));
      chk("id_ex_write", id_ex_write, !frz);
      chk("ex_mem_write", ex_mem_write, !frz);
      chk("if_id_flush", if_id_flush, fl);
      chk("id_ex_bubble", id_ex_bubble, stl);
      chk("mem_wb_bubble", mem_wb_bubble, frz);
      chk("err", err, m_err);
      chk("stall_cnt", stall_cnt, PERF ? (m_stall % mod) : 0);
      chk("flush_cnt", flush_cnt, PERF ? (m_flush % mod) : 0);
      if (frz || stl) m_stall++;
      if (fl) m_flush++;
      m_br_pend = !frz && ex_memread && hz_ex && id_is_branch;
      m_in_wait = frz;
      m_wait    = frz ? m_wait + 1 : 0;
      if (frz && MEM_TIMEOUT > 0 && m_wait >= MEM_TIMEOUT) m_err = 1'b1;
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("post_reset_pc_write", pc_write, 1);
    chk("post_reset_err", err, 0);

    // load-use: one bubble, none on r0
    step(); idle(); ex_memread = 1'b1; ex_rdaddr = 5'd5; id_rsaddr = 5'd5;
    #1; chk("lu_pc_write", pc_write, 0); chk("lu_bubble", id_ex_bubble, 1);
    step(); idle(); mem_memread = 1'b1; mem_rdaddr = 5'd5; id_rsaddr = 5'd5;
    #1; chk("lu_release_pc", pc_write, 1); chk("lu_release_bubble", id_ex_bubble, 0);
    step(); idle(); ex_memread = 1'b1;
    #1; chk("lu_r0_pc", pc_write, 1);

    // load then dependent branch: two bubbles, taken ignored in BR_STALL
    step(); idle(); id_is_branch = 1'b1; ex_memread = 1'b1; ex_rdaddr = 5'd7;
    id_rtaddr = 5'd7; id_uses_rt = 1'b1;
    #1; chk("lbr_bubble1", id_ex_bubble, 1);
    step(); idle(); id_is_branch = 1'b1; id_rtaddr = 5'd7; id_uses_rt = 1'b1; id_branch_taken = 1'b1;
    #1; chk("lbr_bubble2", id_ex_bubble, 1); chk("lbr_flush_held", if_id_flush, 0);
    step(); idle(); id_is_branch = 1'b1; id_branch_taken = 1'b1;
    #1; chk("lbr_flush", if_id_flush, 1); chk("lbr_pc", pc_write, 1);
    step(); idle();
    #1; chk("lbr_flush_end", if_id_flush, 0);

    // ALU result then dependent branch: one bubble
    step(); idle(); id_is_branch = 1'b1; ex_regwrite = 1'b1; ex_rdaddr = 5'd9; id_rsaddr = 5'd9;
    #1; chk("alubr_bubble", id_ex_bubble, 1);
    step(); idle(); id_is_branch = 1'b1; id_rsaddr = 5'd9;
    #1; chk("alubr_release", id_ex_bubble, 0);

    // jump during load-use stall
    step(); idle(); ex_memread = 1'b1; ex_rdaddr = 5'd3; id_rsaddr = 5'd3; id_branch_taken = 1'b1;
    #1; chk("jlu_flush_held", if_id_flush, 0); chk("jlu_pc", pc_write, 0);
    step(); idle(); id_branch_taken = 1'b1;
    #1; chk("jlu_flush", if_id_flush, 1);

    // memory wait: 4 busy cycles, timeout 3
    for (int i = 0; i < 4; i++) begin
      step(); idle(); mem_access = (i == 0); dmem_busy = 1'b1;
      #1;
      chk("mw_bubble", mem_wb_bubble, 1);
      chk("mw_ex_mem_write", ex_mem_write, 0);
      chk("mw_err", err, (i == 3) ? 1 : 0);
    end
    step(); idle();
    #1; chk("mw_exit_pc", pc_write, 1); chk("mw_exit_bubble", mem_wb_bubble, 0); chk("mw_err_sticky", err, 1);
    step(); idle();
    #1; chk("mw_err_sticky2", err, 1);

    // async reset in MEM_WAIT
    step(); idle(); mem_access = 1'b1; dmem_busy = 1'b1;
    step(); mem_access = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    chk("ar_pc_write", pc_write, 0);
    chk("ar_flush", if_id_flush, 1);
    chk("ar_bubble", id_ex_bubble, 1);
    chk("ar_err", err, 0);
    step(); idle(); rst_n = 1'b1; dmem_busy = 1'b1;
    #1; chk("ar_run_pc", pc_write, 1); chk("ar_run_err", err, 0);
    step(); idle();

    // perf: 3 stalls, 2 flushes
    for (int i = 0; i < 3; i++) begin
      step(); idle(); ex_memread = 1'b1; ex_rdaddr = 5'd4; id_rsaddr = 5'd4;
      step(); idle();
    end
    for (int i = 0; i < 2; i++) begin
      step(); idle(); id_branch_taken = 1'b1;
      step(); idle();
    end
    #1;
    chk("perf_stall3", stall_cnt, PERF ? 3 : 0);
    chk("perf_flush2", flush_cnt, PERF ? 2 : 0);

    // perf: 17 stall cycles from reset wrap to 1
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(); idle(); ex_memread = 1'b1; ex_rdaddr = 5'd4; id_rsaddr = 5'd4;
    end
    step(); idle();
    #1;
    chk("perf_stall_wrap", stall_cnt, PERF ? 1 : 0);
    chk("perf_flush_zero", flush_cnt, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
